// File: rtl/imm_decode_pkg.sv
// Shared format codes and RV32I/RV64I major opcodes for the immediate-decode stage.
package imm_decode_pkg;

   localparam logic [2:0] FMT_R    = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_NONE = 3'd7;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   // Opcodes that only exist in RV64 (word-sized ALU ops).
   function automatic logic is_rv64_only(input logic [6:0] opc);
      return (opc == OPC_OP_IMM_32) || (opc == OPC_OP_32);
   endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational decode: instruction word -> format, sign-extended immediate, illegal flag.
// No state; output follows input in the same cycle.
module imm_extract
   import imm_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instruction,
   output logic [XLEN-1:0] immediate,
   output logic [2:0]      format,
   output logic            illegal
);

   localparam bit RV64 = (XLEN == 64);

   logic [6:0]  opcode;
   logic [31:0] imm32;

   assign opcode = instruction[6:0];

   always_comb begin
      imm32   = '0;
      format  = FMT_NONE;
      illegal = 1'b0;
      case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM, OPC_OP_IMM_32: begin
            format = FMT_I;
            imm32  = {{20{instruction[31]}}, instruction[31:20]};
         end
         OPC_STORE: begin
            format = FMT_S;
            imm32  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         end
         OPC_BRANCH: begin
            format = FMT_B;
            imm32  = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            format = FMT_U;
            imm32  = {instruction[31:12], 12'b0};
         end
         OPC_JAL: begin
            format = FMT_J;
            imm32  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
         end
         OPC_OP, OPC_OP_32: begin
            format = FMT_R;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase

      // Word ops and compressed/short encodings collapse to the illegal default.
      if ((is_rv64_only(opcode) && !RV64) || (instruction[1:0] != 2'b11)) begin
         imm32   = '0;
         format  = FMT_NONE;
         illegal = 1'b1;
      end

      immediate = XLEN'($signed(imm32));
   end

endmodule

// File: rtl/immediate_decode_stage.sv
// Registered valid/ready decode stage: 1-cycle latency, decode done at input and stored.
// Backpressure: optional two-entry skid (registered in_ready) or single register with combinational in_ready.
module immediate_decode_stage
   import imm_decode_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit ENABLE_SKID = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instruction,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instruction,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_immediate,
   output logic [2:0]      out_format,
   output logic            out_illegal
);

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } entry_t;

   localparam entry_t ENTRY_RST = '{instr: '0, pc: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0};

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;
   entry_t          in_entry;

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_vld_q, main_vld_d;
   logic   skid_vld_q, skid_vld_d;
   logic   in_ready_q, in_ready_d;
   logic   accept;
   logic   drain;

   imm_extract #(
      .XLEN(XLEN)
   ) u_extract (
      .instruction(in_instruction),
      .immediate  (dec_imm),
      .format     (dec_fmt),
      .illegal    (dec_illegal)
   );

   always_comb begin
      in_entry = '{instr: in_instruction, pc: in_pc, imm: dec_imm,
                   fmt: dec_fmt, illegal: dec_illegal};
   end

   assign in_ready = ENABLE_SKID ? in_ready_q : (!main_vld_q || out_ready);
   assign accept   = in_valid && in_ready && !flush;
   assign drain    = main_vld_q && out_ready;

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q || drain) begin
         // Main slot frees up: the older skid entry always goes first.
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = accept;
            if (accept) begin
               skid_d = in_entry;
            end
         end else begin
            main_vld_d = accept;
            if (accept) begin
               main_d = in_entry;
            end
         end
      end else if (accept) begin
         skid_d     = in_entry;
         skid_vld_d = 1'b1;
      end
      in_ready_d = !skid_vld_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q     <= ENTRY_RST;
         skid_q     <= ENTRY_RST;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign out_valid       = main_vld_q;
   assign out_instruction = main_q.instr;
   assign out_pc          = main_q.pc;
   assign out_immediate   = main_q.imm;
   assign out_format      = main_q.fmt;
   assign out_illegal     = main_q.illegal;

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Directed bench: XLEN=32 with skid buffer and XLEN=64 with single register, hand-computed vectors.
module tb_immediate_decode_stage;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // XLEN=32, skid buffer enabled
   logic        f32, iv32, ir32, ov32, or32, oill32;
   logic [31:0] ins32, pc32, oins32, opc32, oimm32;
   logic [2:0]  ofmt32;

   // XLEN=64, single register
   logic        f64, iv64, ir64, ov64, or64, oill64;
   logic [31:0] ins64, oins64;
   logic [63:0] pc64, opc64, oimm64;
   logic [2:0]  ofmt64;

   immediate_decode_stage #(.XLEN(32), .ENABLE_SKID(1'b1)) dut32 (
      .clk(clk), .reset(reset), .flush(f32),
      .in_valid(iv32), .in_ready(ir32), .in_instruction(ins32), .in_pc(pc32),
      .out_valid(ov32), .out_ready(or32), .out_instruction(oins32), .out_pc(opc32),
      .out_immediate(oimm32), .out_format(ofmt32), .out_illegal(oill32)
   );

   immediate_decode_stage #(.XLEN(64), .ENABLE_SKID(1'b0)) dut64 (
      .clk(clk), .reset(reset), .flush(f64),
      .in_valid(iv64), .in_ready(ir64), .in_instruction(ins64), .in_pc(pc64),
      .out_valid(ov64), .out_ready(or64), .out_instruction(oins64), .out_pc(opc64),
      .out_immediate(oimm64), .out_format(ofmt64), .out_illegal(oill64)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xact32(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] exp_imm, input logic [2:0] exp_fmt, input logic exp_ill);
      iv32  = 1'b1;
      ins32 = instr;
      pc32  = pc;
      check({tag, "/in_ready"}, ir32, 1);
      step();
      iv32 = 1'b0;
      check({tag, "/valid"}, ov32, 1);
      check({tag, "/instr"}, oins32, instr);
      check({tag, "/pc"}, opc32, pc);
      check({tag, "/imm"}, oimm32, exp_imm);
      check({tag, "/fmt"}, ofmt32, exp_fmt);
      check({tag, "/illegal"}, oill32, exp_ill);
      step();
      check({tag, "/drained"}, ov32, 0);
   endtask

   task automatic xact64(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                         input logic [63:0] exp_imm, input logic [2:0] exp_fmt, input logic exp_ill);
      iv64  = 1'b1;
      ins64 = instr;
      pc64  = pc;
      check({tag, "/in_ready"}, ir64, 1);
      step();
      iv64 = 1'b0;
      check({tag, "/valid"}, ov64, 1);
      check({tag, "/pc"}, opc64, pc);
      check({tag, "/imm"}, oimm64, exp_imm);
      check({tag, "/fmt"}, ofmt64, exp_fmt);
      check({tag, "/illegal"}, oill64, exp_ill);
      step();
      check({tag, "/drained"}, ov64, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      f32 = 1'b0; iv32 = 1'b0; or32 = 1'b1; ins32 = '0; pc32 = '0;
      f64 = 1'b0; iv64 = 1'b0; or64 = 1'b1; ins64 = '0; pc64 = '0;
      step();
      reset = 1'b0;

      // Reset state
      check("rst32/valid", ov32, 0);
      check("rst32/in_ready", ir32, 1);
      check("rst32/fmt", ofmt32, 3'd7);
      check("rst32/imm", oimm32, 0);
      check("rst32/instr", oins32, 0);
      check("rst32/illegal", oill32, 0);
      check("rst64/valid", ov64, 0);
      check("rst64/in_ready", ir64, 1);
      check("rst64/fmt", ofmt64, 3'd7);

      // XLEN=32 decode table
      xact32("addi",   32'hFFF00093, 32'h0000_1000, 32'hFFFF_FFFF, 3'd1, 1'b0);
      xact32("sw",     32'hFE112E23, 32'h0000_1004, 32'hFFFF_FFFC, 3'd2, 1'b0);
      xact32("beq",    32'hFE000CE3, 32'h0000_1008, 32'hFFFF_FFF8, 3'd3, 1'b0);
      xact32("jal",    32'h001000EF, 32'h0000_100C, 32'h0000_0800, 3'd5, 1'b0);
      xact32("lui",    32'h123452B7, 32'h0000_1010, 32'h1234_5000, 3'd4, 1'b0);
      xact32("auipc",  32'h80000017, 32'h0000_1014, 32'h8000_0000, 3'd4, 1'b0);
      xact32("add",    32'h002081B3, 32'h0000_1018, 32'h0000_0000, 3'd0, 1'b0);
      xact32("addiw32",32'h0000001B, 32'h0000_101C, 32'h0000_0000, 3'd7, 1'b1);
      xact32("addw32", 32'h0000003B, 32'h0000_1020, 32'h0000_0000, 3'd7, 1'b1);
      xact32("zero",   32'h00000000, 32'h0000_1024, 32'h0000_0000, 3'd7, 1'b1);
      xact32("lw_neg", 32'h80012083, 32'h0000_1028, 32'hFFFF_F800, 3'd1, 1'b0);

      // XLEN=64 decode table
      xact64("addi64",  32'hFFF00093, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
      xact64("lui64",   32'h800002B7, 64'h0000_0000_8000_0004, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
      xact64("addiw64", 32'hFFF0009B, 64'h0000_0000_8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
      xact64("addw64",  32'h0000003B, 64'h0000_0000_8000_000C, 64'h0, 3'd0, 1'b0);
      xact64("beq64",   32'hFE000CE3, 64'h0000_0000_8000_0010, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0);

      // Skid backpressure: A, B, C with three stalled cycles
      or32 = 1'b0;
      iv32 = 1'b1; ins32 = 32'hFFF00093; pc32 = 32'h200;
      check("bp/rdyA", ir32, 1);
      step();
      ins32 = 32'hFE112E23; pc32 = 32'h204;
      check("bp/rdyB", ir32, 1);
      step();
      ins32 = 32'h123452B7; pc32 = 32'h208;
      check("bp/rdy_full", ir32, 0);
      check("bp/A_held", oins32, 32'hFFF00093);
      step();
      check("bp/rdy_still_full", ir32, 0);
      check("bp/A_stable", oins32, 32'hFFF00093);
      check("bp/A_imm_stable", oimm32, 32'hFFFF_FFFF);
      or32 = 1'b1;
      step();
      check("bp/B_valid", ov32, 1);
      check("bp/B_instr", oins32, 32'hFE112E23);
      check("bp/B_imm", oimm32, 32'hFFFF_FFFC);
      check("bp/B_pc", opc32, 32'h204);
      check("bp/rdy_free", ir32, 1);
      step();
      iv32 = 1'b0;
      check("bp/C_valid", ov32, 1);
      check("bp/C_instr", oins32, 32'h123452B7);
      check("bp/C_fmt", ofmt32, 3'd4);
      step();
      check("bp/empty", ov32, 0);

      // Flush while stalled with skid full
      or32 = 1'b0;
      iv32 = 1'b1; ins32 = 32'h00100093; pc32 = 32'h300;
      step();
      ins32 = 32'h00200093; pc32 = 32'h304;
      step();
      ins32 = 32'h00300093; pc32 = 32'h308;
      f32 = 1'b1;
      step();
      f32 = 1'b0; iv32 = 1'b0;
      check("flush/valid", ov32, 0);
      check("flush/in_ready", ir32, 1);
      or32 = 1'b1;
      step();
      check("flush/no_B", ov32, 0);
      step();
      check("flush/no_C", ov32, 0);

      // Flush dominates an accept
      iv32 = 1'b1; ins32 = 32'h00400093; pc32 = 32'h30C;
      f32 = 1'b1;
      step();
      f32 = 1'b0; iv32 = 1'b0;
      check("flush_acc/valid", ov32, 0);

      // Single-register backpressure: in_ready follows out_ready combinationally
      or64 = 1'b0;
      iv64 = 1'b1; ins64 = 32'h123452B7; pc64 = 64'h400;
      step();
      iv64 = 1'b0;
      check("nskid/rdy_stall", ir64, 0);
      step();
      check("nskid/held", ov64, 1);
      check("nskid/imm", oimm64, 64'h0000_0000_1234_5000);
      or64 = 1'b1;
      #1;
      check("nskid/rdy_go", ir64, 1);
      step();
      check("nskid/drained", ov64, 0);

      // Reset mid-stream dominates flush
      or32 = 1'b0;
      iv32 = 1'b1; ins32 = 32'hFE000CE3; pc32 = 32'h500;
      step();
      ins32 = 32'h001000EF; pc32 = 32'h504;
      step();
      iv32 = 1'b0;
      reset = 1'b1; f32 = 1'b1;
      step();
      reset = 1'b0; f32 = 1'b0;
      check("mrst/valid", ov32, 0);
      check("mrst/in_ready", ir32, 1);
      check("mrst/fmt", ofmt32, 3'd7);
      check("mrst/imm", oimm32, 0);
      check("mrst/instr", oins32, 0);
      check("mrst/pc", opc32, 0);
      or32 = 1'b1;
      step();
      check("mrst/no_ghost", ov32, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
